btn_debouncer: RTL and testbench

BTN_DEBOUNCER -- requirements
Module: btn_debouncer

---
 rtl/btn_debouncer.sv | 137 +++++++++++++
 tb/tb_btn_debouncer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debouncer.sv
// Push-button conditioner: two-flop synchronizer, press/release debounce and
// hold-to-auto-repeat, with registered level and one-cycle strobes.
module btn_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic clk100_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_level_o,
  output logic btn_was_pressed_o,
  output logic btn_released_o,
  output logic repeat_active_o
);

  localparam int unsigned TM_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TM_W   = $clog2(TM_MAX);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_CYCLES - 1);
  localparam logic [TM_W-1:0] REP_LAST  = TM_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, btn_s_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [TM_W-1:0]   tm_cnt_q, tm_cnt_d;
  logic              level_q, level_d;
  logic              pressed_q, pressed_d;
  logic              released_q, released_d;
  logic              repeat_q, repeat_d;

  // Counters only advance while below their terminal value, so they can never wrap.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    tm_cnt_d   = tm_cnt_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s_q) begin
          state_d = IDLE;
        end else if (db_cnt_q >= DB_LAST) begin
          state_d   = HELD;
          tm_cnt_d  = '0;
          pressed_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end else if (tm_cnt_q >= HOLD_LAST) begin
          state_d   = REPEAT;
          tm_cnt_d  = '0;
          pressed_d = 1'b1;
        end else begin
          tm_cnt_d = tm_cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!btn_s_q) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end else if (tm_cnt_q >= REP_LAST) begin
          tm_cnt_d  = '0;
          pressed_d = 1'b1;
        end else begin
          tm_cnt_d = tm_cnt_q + 1'b1;
        end
      end
      RELEASE_DB: begin
        if (btn_s_q) begin
          // A release glitch returns to HELD and restarts the hold timer.
          state_d  = HELD;
          tm_cnt_d = '0;
        end else if (db_cnt_q >= DB_LAST) begin
          state_d    = IDLE;
          released_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    level_d  = (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE_DB);
    repeat_d = (state_d == REPEAT);
  end

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b0;
      btn_s_q    <= 1'b0;
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      tm_cnt_q   <= '0;
      level_q    <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      sync1_q    <= btn_i;
      btn_s_q    <= sync1_q;
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      tm_cnt_q   <= tm_cnt_d;
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      repeat_q   <= repeat_d;
    end
  end

  assign btn_level_o       = level_q;
  assign btn_was_pressed_o = pressed_q;
  assign btn_released_o    = released_q;
  assign repeat_active_o   = repeat_q;

endmodule

// File: tb/tb_btn_debouncer.sv
// Bench for btn_debouncer: directed scenarios plus random button activity,
// all checked cycle by cycle against a run-length reference model.
module tb_btn_debouncer;
  localparam int D  = 4;
  localparam int HC = 20;
  localparam int RC = 5;

  logic clk100 = 1'b0;
  logic rst_i  = 1'b1;
  logic btn_i  = 1'b0;
  logic btn_level_o, btn_was_pressed_o, btn_released_o, repeat_active_o;

  int total = 0;
  int bad   = 0;

  btn_debouncer #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)) dut (
    .clk100_i         (clk100),
    .rst_i            (rst_i),
    .btn_i            (btn_i),
    .btn_level_o      (btn_level_o),
    .btn_was_pressed_o(btn_was_pressed_o),
    .btn_released_o   (btn_released_o),
    .repeat_active_o  (repeat_active_o)
  );

  always #5 clk100 = ~clk100;

  // Reference model: the debounced level flips once the synchronized input has
  // disagreed with it for D+1 consecutive edges; timing is kept as timestamps.
  int m_n = 0;
  bit m_hist[2];
  bit m_lvl, m_rep, m_press, m_rel;
  int m_run, m_held_since, m_rep_since;
  logic [3:0] obs, exp_v;

  task automatic model_step(input bit b, input bit r);
    bit s;
    m_n++;
    m_press = 0;
    m_rel   = 0;
    if (r) begin
      m_hist[0] = 0; m_hist[1] = 0;
      m_lvl = 0; m_rep = 0; m_run = 0;
    end else begin
      s = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = b;
      if (s != m_lvl) begin
        m_rep = 0;
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = ~m_lvl;
          m_run = 0;
          if (m_lvl) begin
            m_press = 1;
            m_held_since = m_n;
          end else begin
            m_rel = 1;
          end
        end
      end else if (m_run > 0) begin
        m_run = 0;
        if (m_lvl) m_held_since = m_n;
      end else if (m_lvl) begin
        if (!m_rep && (m_n - m_held_since == HC)) begin
          m_press = 1; m_rep = 1; m_rep_since = m_n;
        end else if (m_rep && ((m_n - m_rep_since) % RC == 0)) begin
          m_press = 1;
        end
      end
    end
  endtask

  task automatic tick(input bit b, input bit r);
    btn_i = b;
    rst_i = r;
    @(posedge clk100);
    model_step(b, r);
    #1;
    obs   = {btn_level_o, btn_was_pressed_o, btn_released_o, repeat_active_o};
    exp_v = {m_lvl, m_press, m_rel, m_rep};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1);
      total++;
      if (obs !== 4'b0000) begin
        bad++; $display("FAIL reset_outputs t=%0d got=%b want=0000", m_n, obs);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL reset_idle t=%0d got=%b want=%b", m_n, obs, exp_v);
      end
    end
    $display("test_reset done t=%0d", m_n);
  endtask

  task automatic test_clean_press();
    int e0, f0, press_at, rel_at, npress, nrel;
    e0 = m_n + 1; press_at = -100; rel_at = -100; npress = 0; nrel = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL press_cycle t=%0d got=%b want=%b", m_n, obs, exp_v);
      end
      if (obs[2]) begin npress++; if (press_at < 0) press_at = m_n; end
    end
    f0 = m_n + 1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL release_cycle t=%0d got=%b want=%b", m_n, obs, exp_v);
      end
      if (obs[1]) begin nrel++; if (rel_at < 0) rel_at = m_n; end
    end
    total++;
    if (press_at - e0 !== 6 || npress !== 1) begin
      bad++; $display("FAIL press_latency got=%0d count=%0d want=6 count=1", press_at - e0, npress);
    end
    total++;
    if (rel_at - f0 !== 6 || nrel !== 1) begin
      bad++; $display("FAIL release_latency got=%0d count=%0d want=6 count=1", rel_at - f0, nrel);
    end
    $display("test_clean_press done press=%0d release=%0d", press_at - e0, rel_at - f0);
  endtask

  task automatic test_bounce();
    bit pat[14];
    int nstrobe, nlvl;
    nstrobe = 0; nlvl = 0;
    for (int i = 0; i < 14; i++) pat[i] = (i < 4) ? ((i % 2) == 0) : 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(pat[i], 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL bounce_cycle t=%0d got=%b want=%b", m_n, obs, exp_v);
      end
      nstrobe += int'(obs[2]) + int'(obs[1]);
      nlvl    += int'(obs[3]);
    end
    total++;
    if (nstrobe !== 0 || nlvl !== 0) begin
      bad++; $display("FAIL bounce_reject strobes=%0d level_cycles=%0d want 0 0", nstrobe, nlvl);
    end
    $display("test_bounce done strobes=%0d", nstrobe);
  endtask

  task automatic test_hold_repeat();
    int e0, nrep;
    int pt[$];
    e0 = m_n + 1; nrep = 0;
    for (int i = 0; i < 46; i++) begin
      tick(1'b1, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL hold_cycle t=%0d got=%b want=%b", m_n, obs, exp_v);
      end
      if (obs[2]) pt.push_back(m_n - e0);
      nrep += int'(obs[0]);
    end
    total++;
    if (pt.size() !== 5 || pt[0] !== 6 || pt[1] !== 26 || pt[2] !== 31 || pt[4] !== 41) begin
      bad++; $display("FAIL repeat_times got n=%0d first=%0d second=%0d want n=5 6 26 31..41",
                      pt.size(), (pt.size() > 0) ? pt[0] : -1, (pt.size() > 1) ? pt[1] : -1);
    end
    total++;
    if (nrep !== 20) begin
      bad++; $display("FAIL repeat_active_cycles got=%0d want=20", nrep);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL hold_release t=%0d got=%b want=%b", m_n, obs, exp_v);
      end
    end
    $display("test_hold_repeat done pulses=%0d", pt.size());
  endtask

  task automatic test_release_glitch();
    int g, nrel, nlow, rep_at;
    nrel = 0; nlow = 0; rep_at = -100;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    g = m_n + 1;
    for (int i = 0; i < 32; i++) begin
      tick((i < 2) ? 1'b0 : 1'b1, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL glitch_cycle t=%0d got=%b want=%b", m_n, obs, exp_v);
      end
      nrel += int'(obs[1]);
      nlow += int'(!obs[3]);
      if (obs[2] && rep_at < 0) rep_at = m_n - g;
    end
    total++;
    if (nrel !== 0 || nlow !== 0 || rep_at !== 24) begin
      bad++; $display("FAIL glitch_hold_restart releases=%0d low=%0d repeat_at=%0d want 0 0 24",
                      nrel, nlow, rep_at);
    end
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    total++;
    if (obs !== 4'b0000) begin
      bad++; $display("FAIL glitch_final got=%b want=0000", obs);
    end
    $display("test_release_glitch done repeat_at=%0d", rep_at);
  endtask

  task automatic test_reset_mid_repeat();
    int e0, npress, press_at;
    npress = 0; press_at = -100;
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b0);
    total++;
    if (obs[0] !== 1'b1) begin
      bad++; $display("FAIL repeat_before_reset got=%b want=1", obs[0]);
    end
    tick(1'b1, 1'b1);
    total++;
    if (obs !== 4'b0000) begin
      bad++; $display("FAIL reset_mid_repeat got=%b want=0000", obs);
    end
    e0 = m_n + 1;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b0);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL post_reset_cycle t=%0d got=%b want=%b", m_n, obs, exp_v);
      end
      if (obs[2]) begin npress++; if (press_at < 0) press_at = m_n - e0; end
    end
    total++;
    if (npress !== 1 || press_at !== 6) begin
      bad++; $display("FAIL post_reset_press count=%0d at=%0d want 1 at 6", npress, press_at);
    end
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    $display("test_reset_mid_repeat done at=%0d", press_at);
  endtask

  task automatic test_random();
    bit b, r;
    int len;
    logic prev_p, prev_r;
    prev_p = 0; prev_r = 0;
    for (int seg = 0; seg < 150; seg++) begin
      b   = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 39) == 0);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        tick(b, r && (i == 0));
        total++;
        if (obs !== exp_v) begin
          bad++; $display("FAIL random_cycle t=%0d btn=%b got=%b want=%b", m_n, b, obs, exp_v);
        end
        total++;
        if ((obs[2] && obs[1]) || (obs[2] && prev_p) || (obs[1] && prev_r)) begin
          bad++; $display("FAIL strobe_exclusive t=%0d got=%b prev=%b%b want no overlap", m_n, obs, prev_p, prev_r);
        end
        prev_p = obs[2];
        prev_r = obs[1];
      end
    end
    $display("test_random done t=%0d", m_n);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repeat();
    test_release_glitch();
    test_reset_mid_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
